ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 205 ++++++++++++++++++++
 tb/tb_ifetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: instruction fetch buffer between the CPU and an 8-bit external memory bus.
// Each 16-bit word is read as two byte transactions (little-endian) and held in buffer A.
// Optional feature: define IFETCH_PREFETCH_EN to add buffer B with a speculative next-word fetch.
module ifetch #(
  parameter logic [15:0] NOP_WORD = 16'h0000,
  parameter logic [15:0] RST_ADDR = 16'h000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic [15:0] ir,
  output logic        stall,
  output logic [16:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

  state_t      state, state_n;
  logic [15:0] fetch_addr, fetch_addr_n;
  logic [7:0]  lo_byte, lo_byte_n;
  logic        valid_a, valid_a_n;
  logic [15:0] tag_a, tag_a_n;
  logic [15:0] word_a, word_a_n;
  logic [16:0] addr_n;
  logic        rd_n;
  logic        hit_a;

  assign hit_a = valid_a && (tag_a == pc_in);

`ifdef IFETCH_PREFETCH_EN
  logic        valid_b, valid_b_n;
  logic [15:0] tag_b, tag_b_n;
  logic [15:0] word_b, word_b_n;
  logic        spec, spec_n;
  logic        hit_b;
  logic [15:0] next_a, next_b;

  assign hit_b  = valid_b && (tag_b == pc_in);
  assign next_a = tag_a + 16'd1;
  assign next_b = tag_b + 16'd1;

  // Instruction presented from whichever buffer matches pc_in.
  always_comb begin
    ir    = NOP_WORD;
    stall = 1'b1;
    if (hit_a) begin
      ir    = word_a;
      stall = 1'b0;
    end else if (hit_b) begin
      ir    = word_b;
      stall = 1'b0;
    end
  end
`else
  // Instruction presented from buffer A when it matches pc_in.
  always_comb begin
    ir    = NOP_WORD;
    stall = 1'b1;
    if (hit_a) begin
      ir    = word_a;
      stall = 1'b0;
    end
  end
`endif

  // Next-state, bus request and buffer update logic.
  always_comb begin
    state_n      = state;
    fetch_addr_n = fetch_addr;
    lo_byte_n    = lo_byte;
    addr_n       = mem_addr;
    rd_n         = mem_rd;
    valid_a_n    = valid_a;
    tag_a_n      = tag_a;
    word_a_n     = word_a;
`ifdef IFETCH_PREFETCH_EN
    valid_b_n    = valid_b;
    tag_b_n      = tag_b;
    word_b_n     = word_b;
    spec_n       = spec;
`endif
    case (state)
      IDLE: begin
`ifdef IFETCH_PREFETCH_EN
        if (hit_a) begin
          if (!valid_b || (tag_b != next_a)) begin
            valid_b_n    = 1'b0;
            spec_n       = 1'b1;
            fetch_addr_n = next_a;
            addr_n       = {next_a, 1'b0};
            rd_n         = 1'b1;
            state_n      = RD_LO;
          end
        end else if (hit_b) begin
          // Promote B into A and immediately look one word further ahead.
          valid_a_n    = 1'b1;
          tag_a_n      = tag_b;
          word_a_n     = word_b;
          valid_b_n    = 1'b0;
          spec_n       = 1'b1;
          fetch_addr_n = next_b;
          addr_n       = {next_b, 1'b0};
          rd_n         = 1'b1;
          state_n      = RD_LO;
        end else begin
          valid_b_n    = 1'b0;
          spec_n       = 1'b0;
          fetch_addr_n = pc_in;
          addr_n       = {pc_in, 1'b0};
          rd_n         = 1'b1;
          state_n      = RD_LO;
        end
`else
        if (!hit_a) begin
          fetch_addr_n = pc_in;
          addr_n       = {pc_in, 1'b0};
          rd_n         = 1'b1;
          state_n      = RD_LO;
        end
`endif
      end
      RD_LO: begin
        if (mem_ack) begin
`ifdef IFETCH_PREFETCH_EN
          // A speculative read that nobody wants stops after the open byte.
          if (spec && !hit_a && (pc_in != fetch_addr)) begin
            rd_n    = 1'b0;
            spec_n  = 1'b0;
            state_n = IDLE;
          end else
`endif
          begin
            lo_byte_n = mem_data;
            addr_n    = {fetch_addr, 1'b1};
            state_n   = RD_HI;
          end
        end
      end
      RD_HI: begin
        if (mem_ack) begin
          rd_n    = 1'b0;
          state_n = IDLE;
`ifdef IFETCH_PREFETCH_EN
          spec_n  = 1'b0;
          if (spec) begin
            if (hit_a || (pc_in == fetch_addr)) begin
              valid_b_n = 1'b1;
              tag_b_n   = fetch_addr;
              word_b_n  = {mem_data, lo_byte};
            end
          end else
`endif
          if (fetch_addr == pc_in) begin
            valid_a_n = 1'b1;
            tag_a_n   = fetch_addr;
            word_a_n  = {mem_data, lo_byte};
          end
        end
      end
      default: begin
        state_n = IDLE;
        rd_n    = 1'b0;
      end
    endcase
  end

  // State, bus and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= RST_ADDR;
      lo_byte    <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      valid_a    <= 1'b0;
      tag_a      <= '0;
      word_a     <= '0;
`ifdef IFETCH_PREFETCH_EN
      valid_b    <= 1'b0;
      tag_b      <= '0;
      word_b     <= '0;
      spec       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      lo_byte    <= lo_byte_n;
      mem_addr   <= addr_n;
      mem_rd     <= rd_n;
      valid_a    <= valid_a_n;
      tag_a      <= tag_a_n;
      word_a     <= word_a_n;
`ifdef IFETCH_PREFETCH_EN
      valid_b    <= valid_b_n;
      tag_b      <= tag_b_n;
      word_b     <= word_b_n;
      spec       <= spec_n;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: byte-wide memory model with programmable wait states,
// directed vector table, hand-written multi-cycle sequences and a randomized phase
// checked against a word-level reference model.
module tb_ifetch;

  localparam logic [15:0] NOP = 16'hF00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in = '0;
  logic [15:0] ir;
  logic        stall;
  logic [16:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;

  ifetch #(.NOP_WORD(NOP), .RST_ADDR(16'h000F)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ir(ir), .stall(stall),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read data, ack after a per-byte number of wait cycles.
  logic [7:0]  mem [131072];
  int unsigned wait_lo = 0, wait_hi = 0, wcnt = 0;
  logic        force_ack = 1'b0;

  assign mem_data = mem[mem_addr];
  assign mem_ack  = (mem_rd && (wcnt == (mem_addr[0] ? wait_hi : wait_lo))) || force_ack;

  always @(posedge clk) wcnt <= (mem_rd && !mem_ack) ? wcnt + 1 : 0;

  // Bus monitor: log completed byte addresses, flag address/request changes while waiting.
  logic [16:0] done_q[$];
  int unsigned viol = 0;
  logic        mon_en = 1'b0;
  logic        p_rd, p_ack, p_rst;
  logic [16:0] p_addr;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd && mem_ack) done_q.push_back(mem_addr);
      if (!p_rst && !(p_rd && p_ack)) begin
        if (p_rd && (!mem_rd || (mem_addr != p_addr))) viol++;
        if (!p_rd && !mem_rd && (mem_addr != p_addr)) viol++;
      end
    end
    p_rd   = mem_rd;
    p_ack  = mem_ack;
    p_rst  = rst;
    p_addr = mem_addr;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {mem[{a, 1'b1}], mem[{a, 1'b0}]};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Present pc just after an edge (also releasing reset) and count stalled cycles.
  task automatic run_fetch(input logic [15:0] pc, output int unsigned sc, output logic to);
    @(posedge clk);
    #1;
    pc_in = pc;
    rst   = 1'b0;
    sc    = 0;
    to    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall) begin
        to = 1'b0;
        break;
      end
      sc++;
    end
  endtask

  typedef struct {
    logic        rst_first;
    logic [15:0] pc;
    int unsigned wl;
    int unsigned wh;
    int unsigned exp_stall;
    logic [15:0] exp_ir;
    int unsigned exp_bytes;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sc;
    int unsigned cnt;
    logic        to;
    logic        found;
    logic        valid_m;
    logic [15:0] tag_m;
    logic [15:0] pc;
    int unsigned wl, wh;
    logic [15:0] pcs[6];

    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[17'h0001E] = 8'h34; mem[17'h0001F] = 8'h12;
    mem[17'h1FFFE] = 8'hCD; mem[17'h1FFFF] = 8'hAB;
    mem[17'h00080] = 8'h9A; mem[17'h00081] = 8'hBC;
    mem[17'h00200] = 8'hEF; mem[17'h00201] = 8'h01;

    vecs[0] = '{1'b1, 16'h000F, 0, 0, 3,  16'h1234, 2};
    vecs[1] = '{1'b0, 16'h000F, 0, 0, 0,  16'h1234, 0};
    vecs[2] = '{1'b1, 16'h000F, 4, 4, 11, 16'h1234, 2};
    vecs[3] = '{1'b0, 16'hFFFF, 0, 0, 3,  16'hABCD, 2};
    vecs[4] = '{1'b0, 16'h0040, 1, 2, 6,  16'hBC9A, 2};
    vecs[5] = '{1'b0, 16'h0100, 0, 3, 6,  16'h01EF, 2};
    vecs[6] = '{1'b0, 16'h0040, 0, 0, 3,  16'hBC9A, 2};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 1'b1);
    check("rst_ir", ir, NOP);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 17'h0);
    mon_en = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) apply_reset();
      wait_lo = vecs[i].wl;
      wait_hi = vecs[i].wh;
      done_q.delete();
      run_fetch(vecs[i].pc, sc, to);
      check($sformatf("v%0d_timeout", i), to, 1'b0);
      check($sformatf("v%0d_stall_cycles", i), sc, vecs[i].exp_stall);
      check($sformatf("v%0d_ir", i), ir, vecs[i].exp_ir);
      check($sformatf("v%0d_nbytes", i), done_q.size(), vecs[i].exp_bytes);
      if (vecs[i].exp_bytes == 2 && done_q.size() == 2) begin
        check($sformatf("v%0d_addr_lo", i), done_q[0], {vecs[i].pc, 1'b0});
        check($sformatf("v%0d_addr_hi", i), done_q[1], {vecs[i].pc, 1'b1});
      end
    end
    check("wait_addr_stable", viol, 0);

    // pc_in changes 0010 -> 0040 while the low byte is outstanding.
    apply_reset();
    wait_lo = 2;
    wait_hi = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pc_in = 16'h0010;
    done_q.delete();
    @(posedge clk);
    #1;
    pc_in = 16'h0040;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stall) begin
        to = 1'b0;
        break;
      end
    end
    check("chg_timeout", to, 1'b0);
    check("chg_ir", ir, 16'hBC9A);
    check("chg_nbytes", done_q.size(), 4);
    if (done_q.size() == 4) begin
      check("chg_b0", done_q[0], 17'h00020);
      check("chg_b1", done_q[1], 17'h00021);
      check("chg_b2", done_q[2], 17'h00080);
      check("chg_b3", done_q[3], 17'h00081);
    end

    // Reset while the high byte is outstanding; a late ack must change nothing.
    apply_reset();
    wait_lo = 0;
    wait_hi = 5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pc_in = 16'h0030;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_rd && mem_addr[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("rdhi_reached", found, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_mem_rd", mem_rd, 1'b0);
    check("midrst_stall", stall, 1'b1);
    check("midrst_ir", ir, NOP);
    check("midrst_addr", mem_addr, 17'h0);
    wait_hi = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_ack = 1'b1;
    done_q.delete();
    @(negedge clk);
    cnt = stall ? 1 : 0;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stall) begin
        to = 1'b0;
        break;
      end
      cnt++;
    end
    check("late_ack_timeout", to, 1'b0);
    check("late_ack_stall_cycles", cnt, 3);
    check("late_ack_ir", ir, word_at(16'h0030));
    check("late_ack_nbytes", done_q.size(), 2);

    // Randomized fetch sequence against a word-level model of buffer A.
    pcs = '{16'h000F, 16'h0010, 16'h0011, 16'h0040, 16'h0100, 16'hFFFF};
    apply_reset();
    valid_m = 1'b0;
    tag_m   = '0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        apply_reset();
        valid_m = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) pc = 16'($urandom);
      else pc = pcs[$urandom_range(0, 5)];
      wl = $urandom_range(0, 3);
      wh = $urandom_range(0, 3);
      wait_lo = wl;
      wait_hi = wh;
      run_fetch(pc, sc, to);
      check($sformatf("r%0d_timeout", n), to, 1'b0);
      check($sformatf("r%0d_stall_cycles", n), sc,
            (valid_m && tag_m == pc) ? 0 : 3 + wl + wh);
      check($sformatf("r%0d_ir", n), ir, word_at(pc));
      valid_m = 1'b1;
      tag_m   = pc;
    end

    check("addr_stability", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
